// File: rtl/sample_window_ring_if.sv
// -----------------------------------------------------------------------------
// sample_window_ring_if
// Handshake / data bundle for sample_window_ring.
//   clear                    : synchronous window flush request
//   inValid/inSample/inReady : sample input handshake
//   outValid/outReady        : output pair handshake
//   firstSample/lastSample   : newest sample / sample leaving the window
//   primed, fillCount        : window occupancy status
//   outSum                   : running window sum (only with SAMPLE_WINDOW_SUM_EN)
// Modports: master = sample producer/consumer side, slave = the ring itself.
// -----------------------------------------------------------------------------
interface sample_window_ring_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8192
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                 clear;
    logic                 inValid;
    logic [WIDTH-1:0]     inSample;
    logic                 inReady;
    logic                 outValid;
    logic                 outReady;
    logic [WIDTH-1:0]     firstSample;
    logic [WIDTH-1:0]     lastSample;
    logic                 primed;
    logic [ADDR_W:0]      fillCount;
`ifdef SAMPLE_WINDOW_SUM_EN
    logic signed [WIDTH+ADDR_W-1:0] outSum;
`endif

    modport master (
        output clear, inValid, inSample, outReady,
        input  inReady, outValid, firstSample, lastSample, primed, fillCount
`ifdef SAMPLE_WINDOW_SUM_EN
        , input outSum
`endif
    );

    modport slave (
        input  clear, inValid, inSample, outReady,
        output inReady, outValid, firstSample, lastSample, primed, fillCount
`ifdef SAMPLE_WINDOW_SUM_EN
        , output outSum
`endif
    );
endinterface

// File: rtl/sample_window_ring.sv
// -----------------------------------------------------------------------------
// sample_window_ring
// Sliding-window sample store built as a ring buffer in inferred synchronous
// RAM. Every accepted sample produces, one cycle later, the pair
// (newest sample, sample evicted from the window) for sliding-DFT bin updates.
//
// Parameters: WIDTH (sample bits, signed), DEPTH (window length, power of 2, >=4)
// Ports:
//   clk  : single clock, posedge
//   rst  : asynchronous active-low reset
//   bus  : sample_window_ring_if.slave (handshakes, pair outputs, status)
// Optional feature macro: SAMPLE_WINDOW_SUM_EN adds bus.outSum, the signed
// running sum of the samples currently in the window.
// -----------------------------------------------------------------------------
module sample_window_ring #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8192
) (
    input  logic                clk,
    input  logic                rst,
    sample_window_ring_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int FILL_W = ADDR_W + 1;
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t              r_state, w_state_nxt;
    logic                w_flush;
    logic                w_in_ready;
    logic                w_accept;

    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic                r_primed;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_first;
    logic                r_evict_en;   // read data of last accept is a real eviction
    logic [WIDTH-1:0]    r_rd_data;
    logic [WIDTH-1:0]    w_last;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_RUN;
        else      r_state <= w_state_nxt;
    end

    // Flush takes effect on the edge that samples clear and is held for the
    // following FLUSH cycle, so status reads zero from the very next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (bus.clear) begin
                    w_state_nxt = S_FLUSH;
                    w_flush     = 1'b1;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_RUN;
                w_flush     = 1'b1;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign w_in_ready = (r_state == S_RUN) && !(r_out_valid && !bus.outReady);
    // clear wins over a simultaneous sample: the sample is dropped.
    assign w_accept   = bus.inValid && w_in_ready && !bus.clear;
    assign w_fill_nxt = (r_fill == FULL) ? r_fill : r_fill + FILL_W'(1);

    // ---------------- RAM (no reset, read-before-write) ----------------
    // Read data register only moves on accept, so it holds during back-pressure.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rd_data          <= r_mem[r_wr_ptr];
            r_mem[r_wr_ptr]    <= bus.inSample;
        end
    end

    // ---------------- control / output registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_first     <= '0;
            r_evict_en  <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_first     <= '0;
            r_evict_en  <= 1'b0;
        end else if (w_accept) begin
            r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);  // DEPTH is a power of two: natural wrap
            r_fill      <= w_fill_nxt;
            r_primed    <= (w_fill_nxt == FULL);
            r_out_valid <= 1'b1;
            r_first     <= bus.inSample;
            // RAM slot only holds a window member once the window was full;
            // this also masks stale contents left over from before reset/flush.
            r_evict_en  <= (r_fill == FULL);
        end else if (bus.outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_last = r_evict_en ? r_rd_data : '0;

    assign bus.inReady     = w_in_ready;
    assign bus.outValid    = r_out_valid;
    assign bus.firstSample = r_first;
    assign bus.lastSample  = w_last;
    assign bus.primed      = r_primed;
    assign bus.fillCount   = r_fill;

`ifdef SAMPLE_WINDOW_SUM_EN
    // The evicted sample is only known a cycle after accept (RAM latency), so
    // the register keeps sum+new and the eviction is subtracted on the output.
    // The partial value may wrap, but the final two's complement result is
    // exact because the true window sum always fits SUM_W bits.
    localparam int SUM_W = WIDTH + ADDR_W;
    logic signed [SUM_W-1:0] r_sum_part;
    logic signed [SUM_W-1:0] w_sum;

    assign w_sum = r_sum_part - $signed({{ADDR_W{w_last[WIDTH-1]}}, w_last});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_sum_part <= '0;
        else if (w_flush)  r_sum_part <= '0;
        else if (w_accept) r_sum_part <= w_sum + $signed({{ADDR_W{bus.inSample[WIDTH-1]}}, bus.inSample});
    end

    assign bus.outSum = w_sum;
`endif

endmodule

// File: tb/tb_sample_window_ring.sv
// -----------------------------------------------------------------------------
// tb_sample_window_ring
// Directed, table-driven bench for sample_window_ring at DEPTH=4, WIDTH=16.
// Inputs are driven 1ns after a rising edge; outputs are compared 1ns after
// the next rising edge.
// -----------------------------------------------------------------------------
module tb_sample_window_ring;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_window_ring_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

    sample_window_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        clr;
        logic        iv;
        logic [15:0] smp;
        logic        ordy;
        logic        ov;
        logic [15:0] first;
        logic [15:0] last;
        logic        primed;
        logic [2:0]  fill;
        logic        irdy;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic clr, logic iv, logic [15:0] smp, logic ordy,
                                logic ov, logic [15:0] first, logic [15:0] last,
                                logic primed, logic [2:0] fill, logic irdy);
        vec_t v;
        v.clr = clr; v.iv = iv; v.smp = smp; v.ordy = ordy;
        v.ov = ov; v.first = first; v.last = last;
        v.primed = primed; v.fill = fill; v.irdy = irdy;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".outValid"},    longint'(bus.outValid),    longint'(v.ov));
        chk({tag, ".firstSample"}, longint'(bus.firstSample), longint'(v.first));
        chk({tag, ".lastSample"},  longint'(bus.lastSample),  longint'(v.last));
        chk({tag, ".primed"},      longint'(bus.primed),      longint'(v.primed));
        chk({tag, ".fillCount"},   longint'(bus.fillCount),   longint'(v.fill));
        chk({tag, ".inReady"},     longint'(bus.inReady),     longint'(v.irdy));
    endtask

    // Called 1ns after a rising edge: drive, clock once, compare.
    task automatic apply(input string tag, input vec_t v);
        bus.clear    = v.clr;
        bus.inValid  = v.iv;
        bus.inSample = v.smp;
        bus.outReady = v.ordy;
        @(posedge clk); #1;
        check_outs(tag, v);
    endtask

    initial begin
        vec_t z;
        rst          = 1'b0;
        bus.clear    = 1'b0;
        bus.inValid  = 1'b0;
        bus.inSample = '0;
        bus.outReady = 1'b1;

        // ---- table: fill, steady state, back-pressure, clear ----
        tbl.push_back(mk(0,1,16'd1,1, 1,16'd1,16'd0,0,3'd1,1));
        tbl.push_back(mk(0,1,16'd2,1, 1,16'd2,16'd0,0,3'd2,1));
        tbl.push_back(mk(0,1,16'd3,1, 1,16'd3,16'd0,0,3'd3,1));
        tbl.push_back(mk(0,1,16'd4,1, 1,16'd4,16'd0,1,3'd4,1));
        for (int n = 5; n <= 10; n++)
            tbl.push_back(mk(0,1,16'(n),1, 1,16'(n),16'(n-4),1,3'd4,1));
        // back-pressure: pair (10,6) held, sample 11 waits
        tbl.push_back(mk(0,1,16'd11,0, 1,16'd10,16'd6,1,3'd4,0));
        tbl.push_back(mk(0,1,16'd11,0, 1,16'd10,16'd6,1,3'd4,0));
        tbl.push_back(mk(0,1,16'd11,1, 1,16'd11,16'd7,1,3'd4,1));
        tbl.push_back(mk(0,0,16'd0,1,  0,16'd11,16'd7,1,3'd4,1));
        // clear with simultaneous sample: sample dropped, FLUSH cycle follows
        tbl.push_back(mk(1,1,16'h7FFF,1, 0,16'd0,16'd0,0,3'd0,0));
        tbl.push_back(mk(0,1,16'd20,1,   0,16'd0,16'd0,0,3'd0,1));
        for (int n = 21; n <= 24; n++)
            tbl.push_back(mk(0,1,16'(n),1, 1,16'(n),16'd0,(n == 24),3'(n-20),1));
        tbl.push_back(mk(0,1,16'd25,1, 1,16'd25,16'd21,1,3'd4,1));
        // six more accepts before the mid-stream reset
        tbl.push_back(mk(0,1,16'd30,1, 1,16'd30,16'd22,1,3'd4,1));
        tbl.push_back(mk(0,1,16'd31,1, 1,16'd31,16'd23,1,3'd4,1));
        tbl.push_back(mk(0,1,16'd32,1, 1,16'd32,16'd24,1,3'd4,1));
        tbl.push_back(mk(0,1,16'd33,1, 1,16'd33,16'd25,1,3'd4,1));
        tbl.push_back(mk(0,1,16'd34,1, 1,16'd34,16'd30,1,3'd4,1));
        tbl.push_back(mk(0,1,16'd35,1, 1,16'd35,16'd31,1,3'd4,1));

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        z = mk(0,0,16'd0,1, 0,16'd0,16'd0,0,3'd0,1);
        check_outs("reset", z);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("v%0d", i), tbl[i]);

        // ---- asynchronous reset mid-stream ----
        bus.inValid = 1'b0;
        rst = 1'b0;
        #2;
        z = mk(0,0,16'd0,1, 0,16'd0,16'd0,0,3'd0,1);
        check_outs("async_rst", z);
        @(posedge clk); #1;
        rst = 1'b1;
        // stale RAM must stay masked until 4 new samples are held
        for (int k = 0; k < 5; k++)
            apply($sformatf("refill%0d", k),
                  mk(0,1,16'(40+k),1, 1,16'(40+k),(k < 4) ? 16'd0 : 16'd40,
                     (k >= 3), (k < 4) ? 3'(k+1) : 3'd4, 1));

`ifdef SAMPLE_WINDOW_SUM_EN
        begin
            longint exp_sum [8];
            exp_sum[0] = 32767;  exp_sum[1] = 65534;  exp_sum[2] = 98301;  exp_sum[3] = 131068;
            exp_sum[4] = 65533;  exp_sum[5] = -2;     exp_sum[6] = -65537; exp_sum[7] = -131072;
            bus.inValid = 1'b0;
            rst = 1'b0;
            #2;
            chk("sum_rst", longint'(bus.outSum), 0);
            @(posedge clk); #1;
            rst = 1'b1;
            for (int k = 0; k < 8; k++) begin
                bus.clear    = 1'b0;
                bus.inValid  = 1'b1;
                bus.inSample = (k < 4) ? 16'h7FFF : 16'h8000;
                bus.outReady = 1'b1;
                @(posedge clk); #1;
                chk($sformatf("sum%0d", k), longint'(bus.outSum), exp_sum[k]);
            end
        end
`endif

        bus.inValid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
